max_window_ctrl: RTL

- Sequencing controller for the signed streaming max-reduction datapath.
- Accepts a window length and a start command, then consumes exactly that many samples over a valid/ready input stream.
- Tracks the running signed maximum and the index of its first occurrence.
- Presents the result on a valid/ready output port and returns to idle; sits between a sample source (e.g. a pooling or peak-detect front end) and a result consumer.

---
 rtl/max_window_pkg.sv | 14 +
 rtl/max_window_acc.sv | 45 ++++
 rtl/max_window_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/max_window_pkg.sv
// Shared definitions for the streaming signed max-reduction controller:
// FSM state encoding and default datapath widths.
package max_window_pkg;

  localparam int D_W_DEF   = 32;
  localparam int LEN_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

endpackage

// File: rtl/max_window_acc.sv
// Registered running signed maximum with the index of its first occurrence.
// load restarts the window with the presented sample at index 0; en offers a
// further sample that replaces the maximum only when strictly greater, so
// ties keep the earlier index.
module max_window_acc
  import max_window_pkg::*;
#(
  parameter int D_W   = D_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [D_W-1:0]   data,
  input  logic [LEN_W-1:0] cnt,
  output logic [D_W-1:0]   acc,
  output logic [LEN_W-1:0] idx
);

  logic [D_W-1:0]   acc_reg;
  logic [LEN_W-1:0] idx_reg;
  logic             greater;

  // Strict signed compare of the new sample against the current maximum
  assign greater = $signed(data) > $signed(acc_reg);

  // Accumulator and index update; active-low synchronous clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_reg <= '0;
      idx_reg <= '0;
    end else if (load) begin
      acc_reg <= data;
      idx_reg <= '0;
    end else if (en && greater) begin
      acc_reg <= data;
      idx_reg <= cnt;
    end
  end

  assign acc = acc_reg;
  assign idx = idx_reg;

endmodule

// File: rtl/max_window_ctrl.sv
// Sequencing controller for a windowed signed max reduction: captures a
// window length on start, consumes exactly that many samples over a
// valid/ready stream, then offers the maximum and its first index on a
// valid/ready result port before returning to idle.
module max_window_ctrl
  import max_window_pkg::*;
#(
  parameter int D_W   = D_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             abort,
  output logic             busy,
  output logic             err,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [D_W-1:0]   s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [D_W-1:0]   m_data,
  output logic [LEN_W-1:0] m_idx
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic [D_W-1:0]   res_data_reg;
  logic [LEN_W-1:0] res_idx_reg;

  logic             s_hs;
  logic             last_hs;
  logic             acc_load;
  logic             acc_en;
  logic [D_W-1:0]   acc;
  logic [LEN_W-1:0] idx;

  assign s_ready  = (state_reg == ACCUM) && !abort;
  assign s_hs     = s_valid && s_ready;
  assign last_hs  = s_hs && (cnt_reg == len_reg - ONE);
  assign acc_load = s_hs && (cnt_reg == '0);
  assign acc_en   = s_hs && (cnt_reg != '0);

  max_window_acc #(
    .D_W   (D_W),
    .LEN_W (LEN_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .load (acc_load),
    .en   (acc_en),
    .data (s_data),
    .cnt  (cnt_reg),
    .acc  (acc),
    .idx  (idx)
  );

  // Next-state, length capture, sample counter and zero-length error pulse
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        // abort in idle swallows a simultaneous start
        if (start && !abort) begin
          if (cfg_len != '0) begin
            len_next   = cfg_len;
            cnt_next   = '0;
            state_next = ACCUM;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (abort) begin
          state_next = IDLE;
        end else if (s_hs) begin
          if (last_hs) begin
            // counter parks at zero so it never passes len-1
            cnt_next   = '0;
            state_next = OUTPUT;
          end else begin
            cnt_next = cnt_reg + ONE;
          end
        end
      end
      OUTPUT: begin
        if (abort || m_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  // Snapshot of the last completed result, shown once the accumulator is
  // reused by the following window
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_data_reg <= '0;
      res_idx_reg  <= '0;
    end else if (state_reg == OUTPUT) begin
      res_data_reg <= acc;
      res_idx_reg  <= idx;
    end
  end

  assign busy    = (state_reg != IDLE);
  assign err     = err_reg;
  assign m_valid = (state_reg == OUTPUT);
  assign m_data  = (state_reg == OUTPUT) ? acc : res_data_reg;
  assign m_idx   = (state_reg == OUTPUT) ? idx : res_idx_reg;

endmodule
